// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-strobed keypad matrix scanner with per-key
// debounce and a first-word-fall-through press/release event FIFO.
// Rows are driven active-low one at a time. Each row's column sample is
// processed one key per cycle during the next row's dwell.
// Optional feature macro: KEYPAD_RELEASE_EVENT_EN. When it is defined,
// release transitions also queue events. When it is undefined, only
// presses are queued and ev_press is tied high.
module keypad_matrix_scanner #(
   parameter int ROWS           = 5,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 8,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int KW             = $clog2(ROWS * COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ROWS-1:0]        btn_x,
   input  logic [COLS-1:0]        btn_y,
   output logic [ROWS*COLS-1:0]   key_state,
   output logic                   ev_valid,
   output logic [KW-1:0]          ev_code,
   output logic                   ev_press,
   input  logic                   ev_ready,
   input  logic                   ovf_clr,
   output logic                   overflow
);

   localparam int KEYS = ROWS * COLS;
   localparam int RW   = $clog2(ROWS);
   localparam int DW   = $clog2(SCAN_DIV);
   localparam int CLW  = $clog2(COLS);
   localparam int CW   = $clog2(DEBOUNCE_SCANS + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);

   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] WALK_LAST  = DW'(COLS - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_SCANS - 1);

   // Active-low one-hot drive pattern for a row index
   function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
      logic [ROWS-1:0] one;
      one = {{(ROWS-1){1'b0}}, 1'b1};
      return ~(one << r);
   endfunction

   logic [RW-1:0]   row_r;
   logic [DW-1:0]   dwell_r;
   logic [COLS-1:0] sample_r;
   logic [RW-1:0]   sample_row_r;
   logic [CW-1:0]   cnt_r [KEYS];

   logic [KW-1:0]   mem_code_r [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_r;
   logic [AW:0]     rd_ptr_r;

   logic            walk_active_s;
   logic [CLW-1:0]  walk_col_s;
   logic [KW-1:0]   walk_key_s;
   logic            raw_s;
   logic            toggle_s;
   logic            push_s;
   logic            empty_s;
   logic            full_s;
   logic            pop_s;
   logic            do_push_s;
   logic            drop_s;
   logic [RW-1:0]   row_next_s;

   // Next row index, wrapping after the last row
   always_comb begin
      row_next_s = row_r + RW'(1);
      if (row_r == ROW_LAST) begin
         row_next_s = '0;
      end else begin
         row_next_s = row_r + RW'(1);
      end
   end

   // Scan counters, row drive and per-row column sample capture
   always_ff @(posedge clk) begin
      if (rst) begin
         row_r        <= '0;
         dwell_r      <= '0;
         btn_x        <= '1;
         sample_r     <= '1;
         sample_row_r <= '0;
      end else if (dwell_r == DWELL_LAST) begin
         dwell_r      <= '0;
         sample_r     <= btn_y;
         sample_row_r <= row_r;
         row_r        <= row_next_s;
         btn_x        <= row_drive(row_next_s);
      end else begin
         dwell_r      <= dwell_r + DW'(1);
         btn_x        <= row_drive(row_r);
      end
   end

   // Select the key under the walk this cycle and decide whether it toggles
   always_comb begin
      walk_active_s = (dwell_r <= WALK_LAST);
      walk_col_s    = dwell_r[CLW-1:0];
      walk_key_s    = KW'(sample_row_r) * KW'(COLS) + KW'(walk_col_s);
      raw_s         = ~sample_r[walk_col_s];
      toggle_s      = 1'b0;
      if (walk_active_s && (raw_s != key_state[walk_key_s])
          && (cnt_r[walk_key_s] == DEB_LAST)) begin
         toggle_s = 1'b1;
      end else begin
         toggle_s = 1'b0;
      end
`ifdef KEYPAD_RELEASE_EVENT_EN
      push_s = toggle_s;
`else
      push_s = toggle_s & raw_s;
`endif
   end

   // Per-key debounce counters and debounced key levels
   always_ff @(posedge clk) begin
      if (rst) begin
         key_state <= '0;
         for (int i = 0; i < KEYS; i++) begin
            cnt_r[i] <= '0;
         end
      end else if (walk_active_s) begin
         if (raw_s == key_state[walk_key_s]) begin
            cnt_r[walk_key_s] <= '0;
         end else if (toggle_s) begin
            key_state[walk_key_s] <= raw_s;
            cnt_r[walk_key_s]     <= '0;
         end else begin
            cnt_r[walk_key_s] <= cnt_r[walk_key_s] + CW'(1);
         end
      end
   end

   // FIFO status and push/pop/drop decisions
   always_comb begin
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s     = ~empty_s & ev_ready;
      do_push_s = push_s & (~full_s | pop_s);
      drop_s    = push_s & full_s & ~pop_s;
   end

   assign ev_valid = ~empty_s;
   assign ev_code  = mem_code_r[rd_ptr_r[AW-1:0]];

`ifdef KEYPAD_RELEASE_EVENT_EN
   logic mem_press_r [FIFO_DEPTH];

   // Event type storage, written alongside the key code
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_press_r[i] <= 1'b0;
         end
      end else if (do_push_s) begin
         mem_press_r[wr_ptr_r[AW-1:0]] <= raw_s;
      end
   end

   assign ev_press = mem_press_r[rd_ptr_r[AW-1:0]];
`else
   assign ev_press = 1'b1;
`endif

   // Event FIFO storage, pointers and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_code_r[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_code_r[wr_ptr_r[AW-1:0]] <= walk_key_s;
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
         if (drop_s) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner (default parameters).
// The bench models the key matrix. Expected events go into a scoreboard
// queue, and a monitor compares every popped event against it.
module tb_keypad_matrix_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  btn_x;
   logic [3:0]  btn_y;
   logic [19:0] key_state;
   logic        ev_valid;
   logic [4:0]  ev_code;
   logic        ev_press;
   logic        ev_ready = 1'b1;
   logic        ovf_clr = 1'b0;
   logic        overflow;

   logic [19:0] held = 20'd0;
   logic [5:0]  exp_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;

   keypad_matrix_scanner #(
      .ROWS(5), .COLS(4), .SCAN_DIV(8), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_x(btn_x), .btn_y(btn_y),
      .key_state(key_state), .ev_valid(ev_valid), .ev_code(ev_code),
      .ev_press(ev_press), .ev_ready(ev_ready), .ovf_clr(ovf_clr),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Matrix model: a column reads low when a held key sits on the driven row
   always_comb begin
      btn_y = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!btn_x[r] && held[r*4+c]) btn_y[c] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_key(input string name, input int k, input logic v, input int budget);
      int n;
      n = 0;
      while (key_state[k] !== v && n < budget) begin
         step();
         n++;
      end
      check(name, {31'd0, key_state[k]}, {31'd0, v});
   endtask

   // Monitor: every accepted head event is compared with the scoreboard
   always @(negedge clk) begin
      if (!rst && ev_valid === 1'b1 && ev_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got code %0d press %0b expected none",
                     ev_code, ev_press);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("event", {26'd0, ev_press, ev_code}, {26'd0, e});
         end
      end
   end

   initial begin
      int keys [5];
      logic [4:0] one;
      int row;
      keys = '{0, 5, 10, 15, 19};

      // Reset state
      repeat (3) step();
      check("rst_btn_x", {27'd0, btn_x}, 32'h1f);
      check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
      check("rst_key_state", {12'd0, key_state}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_ev_code", {27'd0, ev_code}, 32'd0);
`ifdef KEYPAD_RELEASE_EVENT_EN
      check("rst_ev_press", {31'd0, ev_press}, 32'd0);
`else
      check("rst_ev_press", {31'd0, ev_press}, 32'd1);
`endif

      // Row scan sequence: row 0 for the remaining 7 dwell cycles, then 8 each
      rst = 1'b0;
      for (int k = 1; k <= 48; k++) begin
         step();
         row = (k <= 7) ? 0 : (((k - 8) / 8 + 1) % 5);
         one = 5'b00001 << row;
         check("scan_row", {27'd0, btn_x}, {27'd0, ~one});
      end
      for (int f = 0; f < 10; f++) begin
         repeat (40) step();
         check("idle_ev_valid", {31'd0, ev_valid}, 32'd0);
         check("idle_key_state", {12'd0, key_state}, 32'd0);
      end

      // Single press of key 1 (row 0, col 1)
      while (cyc < 2000) step();
      exp_q.push_back({1'b1, 5'd1});
      held[1] = 1'b1;
      wait_key("press_k1", 1, 1'b1, 136);
      repeat (4) step();
      check("press_drained", exp_q.size(), 32'd0);

      // Release of key 1
      held[1] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      exp_q.push_back({1'b0, 5'd1});
`endif
      wait_key("release_k1", 1, 1'b0, 136);
      repeat (4) step();
      check("release_drained", exp_q.size(), 32'd0);

      // Bounce: key 13 closed for exactly two frame samples
      held[13] = 1'b1;
      repeat (80) step();
      held[13] = 1'b0;
      for (int f = 0; f < 3; f++) begin
         repeat (40) step();
         check("bounce_k13", {31'd0, key_state[13]}, 32'd0);
         check("bounce_ev_valid", {31'd0, ev_valid}, 32'd0);
      end

      // Overflow: five presses with no consumer, fifth is dropped
      ev_ready = 1'b0;
      foreach (keys[i]) begin
         if (i < 4) exp_q.push_back({1'b1, keys[i][4:0]});
         held[keys[i]] = 1'b1;
         wait_key("ovf_press", keys[i], 1'b1, 136);
      end
      check("ovf_set", {31'd0, overflow}, 32'd1);
      check("ovf_head_code", {27'd0, ev_code}, 32'd0);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_clr", {31'd0, overflow}, 32'd0);
      ev_ready = 1'b1;
      repeat (4) step();
      check("drain_ev_valid", {31'd0, ev_valid}, 32'd0);
      check("drain_count", exp_q.size(), 32'd0);

      // Reset mid-operation: two queued events, key 7 mid-debounce
      ev_ready = 1'b0;
      held[2] = 1'b1;
      wait_key("mid_k2", 2, 1'b1, 136);
      held[3] = 1'b1;
      wait_key("mid_k3", 3, 1'b1, 136);
      check("mid_ev_valid", {31'd0, ev_valid}, 32'd1);
      held[7] = 1'b1;
      repeat (45) step();
      check("mid_k7_pending", {31'd0, key_state[7]}, 32'd0);
      rst = 1'b1;
      held = 20'd0;
      step();
      check("mrst_ev_valid", {31'd0, ev_valid}, 32'd0);
      check("mrst_key_state", {12'd0, key_state}, 32'd0);
      check("mrst_btn_x", {27'd0, btn_x}, 32'h1f);
      check("mrst_overflow", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      ev_ready = 1'b1;
      repeat (120) step();
      check("post_rst_key_state", {12'd0, key_state}, 32'd0);
      check("post_rst_ev_valid", {31'd0, ev_valid}, 32'd0);

      // Key 7 needs a full debounce again after reset
      exp_q.push_back({1'b1, 5'd7});
      held[7] = 1'b1;
      wait_key("post_press_k7", 7, 1'b1, 136);
      repeat (4) step();
      check("post_press_drained", exp_q.size(), 32'd0);
      held[7] = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      exp_q.push_back({1'b0, 5'd7});
`endif
      wait_key("post_release_k7", 7, 1'b0, 136);
      repeat (4) step();
      check("post_release_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised keypad matrix scanner for the cyber_melody board, replacing ad-hoc row/column polling of the 5×4 button matrix. It drives one active-low row at a time and samples the active-low column inputs. Each key is debounced independently, and press/release events are queued in a small FIFO with a valid/ready handshake. It sits between the board's btn_x/btn_y pins and the game/melody logic, which consumes key codes.

## Interface
- ROWS, 5: matrix rows (btn_x width), ≥2
- COLS, 4: matrix columns (btn_y width), ≥2
- SCAN_DIV, 8: clock cycles each row is driven; must be ≥ COLS+1
- DEBOUNCE_SCANS, 3: consecutive identical frame samples needed to change a key's state, 1..15
- FIFO_DEPTH, 4: event FIFO entries, power of 2, ≥2
- KW (derived) = clog2(ROWS*COLS): key code width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_x  out  ROWS  row drive; selected row 0, others 1
- btn_y  in  COLS  column sense, externally pulled up; 0 = key closed on the driven row
- key_state  out  ROWS*COLS  debounced level per key, bit index = code, 1 = pressed
- ev_valid  out  1  FIFO non-empty
- ev_code  out  KW  key code of head event = row*COLS + col
- ev_press  out  1  head event type; 1 = press, 0 = release
- ev_ready  in  1  consumer accepts head event
- ovf_clr  in  1  clears overflow
- overflow  out  1  sticky; an event was dropped

## Operation
- Scan: row index r and dwell counter d (0..SCAN_DIV-1).
  - btn_x = ~(1<<r).
  - At d = SCAN_DIV-1, btn_y is latched into a sample register tagged with r.
  - r then advances, wrapping from ROWS-1 to 0.
- Frame = ROWS*SCAN_DIV cycles.
- Key update walk: in dwell cycles d = 0..COLS-1 of the following row, key (tagged r, col d) is processed, one key per cycle.
  - pressed_raw = ~sample[d].
  - If pressed_raw equals key_state: that key's counter clears.
  - Otherwise: the counter increments. On reaching DEBOUNCE_SCANS, key_state toggles, the counter clears, and one event is pushed (ev_press = new state).
- Because keys are serialised, at most one push per cycle, so there are no simultaneous push conflicts.
- FIFO is first-word-fall-through:
  - ev_code and ev_press are valid whenever ev_valid = 1.
  - Pop occurs on ev_valid & ev_ready.
  - ev_ready while empty is ignored.
- Full FIFO:
  - push without pop: event dropped, overflow ← 1. key_state still updates.
  - push with pop in the same cycle: both occur, no overflow.
  - push into empty FIFO: ev_valid rises the next cycle.
- overflow is cleared by ovf_clr. If a drop and ovf_clr coincide, the drop wins (overflow stays 1).
- Multiple pressed keys (including ghosting combinations) are reported as sampled; no ghost suppression.

## Timing
- Reset values:
  - btn_x = all ones; r = 0, d = 0.
  - key_state = 0, all debounce counters = 0.
  - FIFO empty, ev_valid = 0, ev_code = 0, ev_press = 0.
  - overflow = 0.
- First cycle after rst deasserts: btn_x = ~1 (row 0 driven).
- Reset asserted mid-scan or mid-walk: all of the above restored on the next edge. Pending FIFO contents and partial debounce counts are discarded.
- Press latency: a key closed continuously is reported within DEBOUNCE_SCANS frames + 2*SCAN_DIV cycles. key_state and the FIFO push occur on the same edge; ev_valid follows one cycle later.
- Bounce rule: a glitch lasting fewer than DEBOUNCE_SCANS consecutive frame samples produces no key_state change and no event.
- Throughput: one pop per cycle sustained.

## Configuration
- KEYPAD_RELEASE_EVENT_EN
  - Defined: release transitions push events with ev_press = 0, as described above.
  - Undefined:
    - Release transitions still update key_state but push nothing.
    - ev_press is tied to 1.
    - A FIFO-full drop on release cannot occur.

## Test plan
Defaults: ROWS=5, COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=4, frame = 40 cycles. The bench models the matrix: btn_y[c] = 0 iff key (r,c) is held and btn_x[r] = 0.

- Reset/scan: release rst, hold no keys.
  - btn_x steps 11110→11101→11011→10111→01111→11110, 8 cycles each.
  - ev_valid stays 0 and key_state = 0 for 10 frames.
- Single press: hold row 0 / col 1 (btn_x=11110, btn_y=1101) from cycle 2000, ev_ready = 1.
  - Within 3 frames + 16 cycles, key_state[1] = 1.
  - One event: ev_code = 1, ev_press = 1.
- Bounce: close key 13 (row 3, col 1) for 2 frames, then open.
  - No event; key_state[13] stays 0.
- Release (macro defined): release key 1 after the press test.
  - Event ev_code = 1, ev_press = 0.
- Release (macro undefined): same stimulus.
  - key_state[1] returns to 0; no event.
- Overflow: ev_ready = 0, press keys 0, 5, 10, 15, 19 one at a time.
  - FIFO holds codes 0, 5, 10, 15 in order; overflow = 1.
  - Pulse ovf_clr → overflow = 0.
  - Draining with ev_ready = 1 gives 4 pops then ev_valid = 0.
- Reset mid-operation: assert rst while FIFO holds 2 events and key 7 is mid-debounce.
  - Next cycle: ev_valid = 0, key_state = 0, btn_x = 11111.
